conv_row_sequencer: RTL and testbench

- Hardware initiator for the conv PE array top-level; replaces bench-driven sequencing of set_wgt/set_ifm/FIFO enables.
- Accepts a weight word and a row-major ifm stream via valid/ready, and forwards them to the array.
- Schedules per-row psum FIFO write/read enables for the KERNEL_SIZE row pipeline, then drains the last-row FIFO under downstream backpressure.

---
 rtl/conv_row_sequencer_pkg.sv | 15 +
 rtl/conv_seq_counter.sv | 19 +
 rtl/conv_row_sequencer.sv | 94 +++++++++
 tb/tb_conv_row_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/conv_row_sequencer_pkg.sv
// conv_row_sequencer_pkg: shared state encoding and derived constants for the row sequencer
package conv_row_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    LOAD_WGT = 3'd2,
    ROW      = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_t;
  function automatic int out_per_row(input int row_len, input int k);
    return row_len - k + 1;
  endfunction
  localparam int OUT_PER_ROW = out_per_row(9, 3);
endpackage

// File: rtl/conv_seq_counter.sv
// conv_seq_counter: clearable up-counter that wraps to zero after WRAP-1 and flags its terminal value
module conv_seq_counter #(
  parameter int WIDTH = 4,
  parameter int WRAP  = 9
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);
  assign last = cnt == WIDTH'(WRAP - 1);
  // count on enable, wrapping at the terminal value so the counter never runs past it
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/conv_row_sequencer.sv
// conv_row_sequencer: loads the kernel, streams ifm rows and schedules psum FIFO enables for the PE array
module conv_row_sequencer
  import conv_row_sequencer_pkg::*;
#(
  parameter int IFM_WIDTH    = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int ROW_LEN      = 9,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                                        clk1,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] wgt_in,
  input  logic                                        wgt_valid,
  output logic                                        wgt_ready,
  input  logic [IFM_WIDTH-1:0]                        ifm_in,
  input  logic                                        ifm_valid,
  output logic                                        ifm_ready,
  input  logic                                        drain_ready,
  output logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] wgt,
  output logic [IFM_WIDTH-1:0]                        ifm,
  output logic                                        set_wgt,
  output logic                                        set_ifm,
  output logic [KERNEL_SIZE-1:0]                      wr_en,
  output logic [KERNEL_SIZE-1:0]                      rd_en,
  output logic                                        rd_clr,
  output logic                                        wr_clr,
  output logic                                        busy,
  output logic                                        done
);
  localparam int OPR = out_per_row(ROW_LEN, KERNEL_SIZE);
  state_t state, state_d;
  logic [CNT_WIDTH-1:0] col, row, d;
  logic col_last, row_last, d_last, cnt_clr, wgt_acc, ifm_acc, drn_acc, row_out, set_wgt_d;
  logic [KERNEL_SIZE-1:0] wr_en_d, rd_en_d;
  conv_seq_counter #(.WIDTH(CNT_WIDTH), .WRAP(ROW_LEN)) u_col (
    .clk1(clk1), .rst_n(rst_n), .clr(cnt_clr), .en(ifm_acc), .cnt(col), .last(col_last)
  );
  conv_seq_counter #(.WIDTH(CNT_WIDTH), .WRAP(KERNEL_SIZE)) u_row (
    .clk1(clk1), .rst_n(rst_n), .clr(cnt_clr), .en(ifm_acc && col_last), .cnt(row), .last(row_last)
  );
  conv_seq_counter #(.WIDTH(CNT_WIDTH), .WRAP(OPR)) u_drain (
    .clk1(clk1), .rst_n(rst_n), .clr(cnt_clr), .en(drn_acc), .cnt(d), .last(d_last)
  );
  // state register
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // accepts, next-cycle enables and next state; a row writes its FIFO once a full kernel window is in
  always_comb begin
    wgt_acc = state == LOAD_WGT && wgt_valid;
    ifm_acc = state == ROW && ifm_valid;
    drn_acc = state == DRAIN && drain_ready && d < CNT_WIDTH'(OPR);
    row_out = ifm_acc && col >= CNT_WIDTH'(KERNEL_SIZE - 1);
    cnt_clr = state == CLEAR;
    set_wgt_d = wgt_acc || (ifm_acc && col == '0);
    wr_en_d = row_out ? KERNEL_SIZE'(1) << row : '0;
    rd_en_d = row_out && row != '0 ? KERNEL_SIZE'(1) << (row - 1'b1) :
              drn_acc ? KERNEL_SIZE'(1) << (KERNEL_SIZE - 1) : '0;
    state_d = state;
    case (state)
      IDLE:     if (start) state_d = CLEAR;
      CLEAR:    state_d = LOAD_WGT;
      LOAD_WGT: if (wgt_acc) state_d = ROW;
      ROW:      if (ifm_acc && col_last && row_last) state_d = DRAIN;
      DRAIN:    if (drn_acc && d_last) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // registered outputs, all derived from the upcoming state and this cycle's accepts
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      {busy, done, rd_clr, wr_clr, wgt_ready, ifm_ready, set_wgt, set_ifm} <= '0;
      wr_en <= '0;
      rd_en <= '0;
      wgt <= '0;
      ifm <= '0;
    end else begin
      busy <= state_d != IDLE;
      done <= state_d == DONE;
      rd_clr <= state_d == CLEAR;
      wr_clr <= state_d == CLEAR;
      wgt_ready <= state_d == LOAD_WGT;
      ifm_ready <= state_d == ROW;
      set_wgt <= set_wgt_d;
      set_ifm <= ifm_acc;
      wr_en <= wr_en_d;
      rd_en <= rd_en_d;
      wgt <= wgt_acc ? wgt_in : wgt;
      ifm <= ifm_acc ? ifm_in : ifm;
    end
endmodule

// File: tb/tb_conv_row_sequencer.sv
// tb_conv_row_sequencer: scoreboard bench driving full jobs, bubbles, backpressure, ignored start and mid-job reset
module tb_conv_row_sequencer;
  logic clk1 = 0, rst_n, start, wgt_valid, wgt_ready, ifm_valid, ifm_ready, drain_ready;
  logic [71:0] wgt_in, wgt;
  logic [7:0] ifm_in, ifm;
  logic set_wgt, set_ifm, rd_clr, wr_clr, busy, done;
  logic [2:0] wr_en, rd_en;
  typedef struct packed {
    logic busy, done, rclr, wclr, wrdy, irdy, swgt, sifm;
    logic [2:0] wr, rd;
    logic [7:0] ifm;
    logic [71:0] wgt;
  } vec_t;
  vec_t q[$];
  int n_chk = 0, n_err = 0;
  int m_st, m_row, m_col, m_d;
  logic [7:0] m_ifm;
  logic [71:0] m_wgt;
  int c_sw, c_si, c_done;
  int c_wr[3], c_rd[3];
  bit ab;
  always #5 clk1 = ~clk1;
  conv_row_sequencer dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .wgt_in(wgt_in), .wgt_valid(wgt_valid),
    .wgt_ready(wgt_ready), .ifm_in(ifm_in), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
    .drain_ready(drain_ready), .wgt(wgt), .ifm(ifm), .set_wgt(set_wgt), .set_ifm(set_ifm),
    .wr_en(wr_en), .rd_en(rd_en), .rd_clr(rd_clr), .wr_clr(wr_clr), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic vec_t act();
    return vec_t'({busy, done, rd_clr, wr_clr, wgt_ready, ifm_ready, set_wgt, set_ifm, wr_en, rd_en, ifm, wgt});
  endfunction
  task automatic model_reset();
    m_st = 0; m_row = 0; m_col = 0; m_d = 0; m_ifm = '0; m_wgt = '0;
    q.delete();
  endtask
  // reference behaviour: expected outputs after the next edge, pushed to the scoreboard
  task automatic model(input logic s, input logic wv, input logic iv, input logic [7:0] iin, input logic dr);
    vec_t e = '0;
    int ns = m_st;
    case (m_st)
      0: if (s) ns = 1;
      1: ns = 2;
      2: if (wv) begin m_wgt = wgt_in; e.swgt = 1; m_row = 0; m_col = 0; ns = 3; end
      3: if (iv) begin
        m_ifm = iin;
        e.sifm = 1;
        if (m_col == 0) e.swgt = 1;
        if (m_col >= 2) begin
          e.wr[m_row] = 1;
          if (m_row > 0) e.rd[m_row-1] = 1;
        end
        if (m_col == 8) begin
          m_col = 0;
          m_row++;
          if (m_row == 3) begin ns = 4; m_d = 0; end
        end else m_col++;
      end
      4: if (dr) begin e.rd[2] = 1; m_d++; if (m_d == 7) ns = 5; end
      default: ns = 0;
    endcase
    m_st = ns;
    e.busy = ns != 0; e.done = ns == 5; e.rclr = ns == 1; e.wclr = ns == 1;
    e.wrdy = ns == 2; e.irdy = ns == 3; e.ifm = m_ifm; e.wgt = m_wgt;
    q.push_back(e);
  endtask
  task automatic tick(input logic s, input logic wv, input logic iv, input logic [7:0] iin, input logic dr);
    vec_t e;
    start = s; wgt_valid = wv; ifm_valid = iv; ifm_in = iin; drain_ready = dr;
    model(s, wv, iv, iin, dr);
    @(posedge clk1); #1;
    e = q.pop_front();
    check("outputs", act(), e);
    check("wr_rd_same_fifo", wr_en & rd_en, 0);
    check("wr_onehot", $countones(wr_en) <= 1, 1);
    c_sw += set_wgt; c_si += set_ifm; c_done += done;
    for (int k = 0; k < 3; k++) begin c_wr[k] += wr_en[k]; c_rd[k] += rd_en[k]; end
  endtask
  task automatic run_job(input bit bubble, input bit toggle, input bit start_row, input bit abort, output bit aborted);
    int e = 0, bub = 0, guard = 0;
    bit started = 0;
    logic s, wv, iv, dr;
    logic [7:0] v;
    aborted = 0;
    c_sw = 0; c_si = 0; c_done = 0;
    for (int k = 0; k < 3; k++) begin c_wr[k] = 0; c_rd[k] = 0; end
    while (guard < 400) begin
      guard++;
      if (abort && m_st == 3 && m_row == 1 && m_col == 4) begin
        start = 0; wgt_valid = 0; ifm_valid = 0; drain_ready = 0;
        rst_n = 0;
        #1;
        check("rst_mid_outputs", act(), 0);
        check("rst_mid_busy", busy, 0);
        model_reset();
        repeat (2) @(posedge clk1);
        #1 rst_n = 1;
        aborted = 1;
        return;
      end
      s = !started || (start_row && m_st == 3 && e == 12);
      started = 1;
      wv = m_st == 2;
      iv = m_st == 3 && !(bubble && e == 5 && bub < 2);
      if (m_st == 3 && !iv) bub++;
      v = iv ? 8'(e / 9 + 1 + e % 9) : 8'hEE;
      dr = toggle ? guard % 2 == 1 : 1'b1;
      if (iv) e++;
      tick(s, wv, iv, v, dr);
      if (m_st == 0) break;
    end
    check("job_terminates", guard < 400, 1);
  endtask
  task automatic check_counts();
    check("n_set_wgt", c_sw, 4);
    check("n_set_ifm", c_si, 27);
    check("n_done", c_done, 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("n_wr_en%0d", k), c_wr[k], 7);
      check($sformatf("n_rd_en%0d", k), c_rd[k], 7);
    end
  endtask
  initial begin
    rst_n = 0; start = 0; wgt_valid = 0; ifm_valid = 0; drain_ready = 0; ifm_in = '0;
    wgt_in = 72'h010203010203010203;
    model_reset();
    repeat (2) @(posedge clk1);
    #1;
    check("reset", act(), 0);
    rst_n = 1;
    run_job(0, 0, 0, 0, ab); check_counts();
    wgt_in = 72'hA5A5_0F0F_1234_5678_9A;
    run_job(1, 0, 0, 0, ab); check_counts();
    run_job(0, 1, 0, 0, ab); check_counts();
    wgt_in = 72'h010203010203010203;
    run_job(0, 0, 1, 0, ab); check_counts();
    run_job(0, 0, 0, 1, ab);
    check("aborted", ab, 1);
    run_job(0, 0, 0, 0, ab); check_counts();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
